// File: rtl/el2_lsu_ecc_scrub.sv
// el2_lsu_ecc_scrub: queues corrected SEC load words and writes them back to DCCM with fresh ECC
// EL2_SCRUB_ERRCNT_EN enables the saturating scrub counter and an internal drop counter
module el2_lsu_ecc_scrub #(
    parameter int DEPTH      = 2,
    parameter int DCCM_BITS  = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ECC_WIDTH  = 7,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sec_lo_r,
    input  logic                  sec_hi_r,
    input  logic [DCCM_BITS-1:0]  sec_addr_lo_r,
    input  logic [DCCM_BITS-1:0]  sec_addr_hi_r,
    input  logic [DATA_WIDTH-1:0] sec_data_lo_r,
    input  logic [DATA_WIDTH-1:0] sec_data_hi_r,
    input  logic                  ext_wr_en,
    input  logic [DCCM_BITS-1:0]  ext_wr_addr,
    output logic                  dccm_wr_req,
    input  logic                  dccm_wr_gnt,
    output logic [DCCM_BITS-1:0]  dccm_wr_addr,
    output logic [DATA_WIDTH-1:0] dccm_wr_data,
    output logic [ECC_WIDTH-1:0]  dccm_wr_ecc,
    output logic                  scrub_busy,
    output logic                  scrub_ovf,
    output logic [CNT_WIDTH-1:0]  scrub_cnt
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, REQ} state_t;
    state_t state, nxt_state;

    logic [DCCM_BITS-1:0]  q_addr [DEPTH];
    logic [DATA_WIDTH-1:0] q_data [DEPTH];
    logic [DEPTH-1:0]      q_vld, n_vld, hit;
    logic [PW-1:0]         rd_ptr, wr_ptr, slot_hi, n_rd;
    logic [PW:0]           count, free, need, n_cnt;
    logic                  push_lo, push_hi, push_ok, pop, gnt_pop, kill, ovf_now;

    function automatic logic same_word(input logic [DCCM_BITS-1:0] a, input logic [DCCM_BITS-1:0] b);
        return a[DCCM_BITS-1:2] == b[DCCM_BITS-1:2];
    endfunction

    function automatic logic [6:0] rvecc_encode(input logic [31:0] d);
        logic [5:0] e;
        e[0] = ^(d & 32'h56AA_AD5B);
        e[1] = ^(d & 32'h9B33_366D);
        e[2] = ^(d & 32'hE3C3_C78E);
        e[3] = ^(d & 32'h03FC_07F0);
        e[4] = ^(d & 32'h03FF_F800);
        e[5] = ^(d & 32'hFC00_0000);
        return {^{d, e}, e};
    endfunction

    for (genvar i = 0; i < DEPTH; i++) begin : g_hit
        assign hit[i] = ext_wr_en && same_word(q_addr[i], ext_wr_addr);
    end

    // A capture to a word being overwritten this cycle is already stale
    assign push_lo = sec_lo_r && !(ext_wr_en && same_word(ext_wr_addr, sec_addr_lo_r));
    assign push_hi = sec_hi_r && !(sec_lo_r && same_word(sec_addr_lo_r, sec_addr_hi_r))
                     && !(ext_wr_en && same_word(ext_wr_addr, sec_addr_hi_r));
    assign kill    = !q_vld[rd_ptr] || hit[rd_ptr];
    assign gnt_pop = (state == REQ) && dccm_wr_gnt;
    assign pop     = (count != '0) && ((state == REQ) ? (dccm_wr_gnt || kill) : !q_vld[rd_ptr]);
    assign free    = (PW+1)'(DEPTH) - count + {{PW{1'b0}}, pop};
    assign need    = {{PW{1'b0}}, push_lo} + {{PW{1'b0}}, push_hi};
    assign ovf_now = need > free;
    assign push_ok = !ovf_now;
    assign slot_hi = push_lo ? wr_ptr + PW'(1) : wr_ptr;
    assign n_rd    = rd_ptr + PW'(pop);
    assign n_cnt   = count - {{PW{1'b0}}, pop} + (push_ok ? need : '0);

    always_comb begin
        n_vld = q_vld & ~hit;
        if (push_ok && push_lo) n_vld[wr_ptr] = 1'b1;
        if (push_ok && push_hi) n_vld[slot_hi] = 1'b1;
        nxt_state = ((state == REQ && !pop)
                    || (((state == IDLE && !pop) || gnt_pop) && n_cnt != '0 && n_vld[n_rd])) ? REQ : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            q_vld     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            scrub_ovf <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                q_addr[k] <= '0;
                q_data[k] <= '0;
            end
        end else begin
            state     <= nxt_state;
            q_vld     <= n_vld;
            rd_ptr    <= n_rd;
            count     <= n_cnt;
            scrub_ovf <= ovf_now;
            wr_ptr    <= wr_ptr + PW'(push_ok ? need : '0);
            if (push_ok && push_lo) begin
                q_addr[wr_ptr] <= sec_addr_lo_r;
                q_data[wr_ptr] <= sec_data_lo_r;
            end
            if (push_ok && push_hi) begin
                q_addr[slot_hi] <= sec_addr_hi_r;
                q_data[slot_hi] <= sec_data_hi_r;
            end
        end
    end

    assign dccm_wr_req  = (state == REQ);
    assign dccm_wr_addr = q_addr[rd_ptr];
    assign dccm_wr_data = q_data[rd_ptr];
    assign dccm_wr_ecc  = rvecc_encode(dccm_wr_data);
    assign scrub_busy   = (count != '0) || (state == REQ);

`ifdef EL2_SCRUB_ERRCNT_EN
    logic [CNT_WIDTH-1:0] cnt_q, drop_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            drop_cnt <= '0;
        end else begin
            if (gnt_pop && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
            if ((ovf_now || |(q_vld & hit)) && !(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
        end
    end
    assign scrub_cnt = cnt_q;
`else
    assign scrub_cnt = '0;
`endif
endmodule
